// File: rtl/mix_stream_checker_if.sv
// rtl/mix_stream_checker_if.sv - valid/ready word stream into the mix-state checker
interface mix_stream_checker_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/mix_stream_checker.sv
// rtl/mix_stream_checker.sv - mix-state stream checker with serial mix engine; macro MIX_CHECK_RESYNC_EN re-locks exp on received frames
module mix_stream_checker #(
    parameter int ROUNDS = 2,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_stream_checker_if.slave  s_in,
    input  logic                 i_resync,
    output logic                 o_busy,
    output logic                 o_frame_done,
    output logic                 o_frame_ok,
    output logic [7:0]           o_err_word_mask,
    output logic [CNT_W-1:0]     o_frame_cnt,
    output logic [CNT_W-1:0]     o_err_cnt
);
    localparam int STEPS = 64 * ROUNDS;
    localparam int SW    = $clog2(STEPS);
    localparam logic [7:0][7:0]  KA = {8'd19, 8'd17, 8'd13, 8'd11, 8'd7, 8'd5, 8'd3, 8'd2};
    localparam logic [7:0][7:0]  KB = {8'd23, 8'd19, 8'd17, 8'd13, 8'd11, 8'd7, 8'd5, 8'd3};
    localparam logic [7:0][7:0]  KC = {8'd87, 8'd35, 8'd13, 8'd5, 8'd3, 8'd3, 8'd3, 8'd2};
    localparam logic [7:0][15:0] KD = {16'd343, 16'd216, 16'd125, 16'd64, 16'd27, 16'd8, 16'd1, 16'd0};

    typedef enum logic [1:0] {SEED, COLLECT, COMPUTE} state_t;

    state_t           r_state;
    logic [2:0]       r_idx;
    logic [SW-1:0]    r_step;
    logic [31:0]      r_cur [8];
    logic [31:0]      r_exp [8];
    logic [7:0]       r_mask;
    logic             r_frame_done;
    logic             r_frame_ok;
    logic [7:0]       r_err_mask;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_xfer;
    logic             w_last;
    logic [7:0]       w_mask;
    logic [31:0]      w_frame [8];
    logic [2:0]       w_wi;
    logic [2:0]       w_st;
    logic [31:0]      w_s;
    logic [31:0]      w_new;

    always_comb begin
        w_xfer = s_in.in_valid && (r_state != COMPUTE) && !i_resync;
        w_last = w_xfer && (r_idx == 3'd7);
        w_mask = r_mask;
        if (s_in.in_data != r_exp[r_idx])
            w_mask[r_idx] = 1'b1;
        for (int k = 0; k < 8; k++)
            w_frame[k] = r_cur[k];
        w_frame[r_idx] = s_in.in_data;

        // step counter = {round, stage, word}; words update in place so later words see new values
        w_wi  = r_step[2:0];
        w_st  = r_step[5:3];
        w_s   = r_exp[w_wi];
        w_new = w_s;
        case (w_st)
            3'd0:    w_new = w_s + {29'd0, w_wi};
            3'd1:    w_new = w_s + r_exp[w_wi - 3'd1];
            3'd2:    w_new = w_s + r_exp[w_wi + 3'd1] - r_exp[w_wi + 3'd5];
            3'd3:    w_new = w_s ^ (r_exp[w_wi + 3'd3] << 16);
            3'd4:    w_new = w_s - (r_exp[w_wi + 3'd2] >> 17) + (r_exp[w_wi + 3'd4] >> 12);
            3'd5:    w_new = w_s + r_exp[w_wi - 3'd1] - r_exp[w_wi - 3'd2];
            3'd6:    w_new = w_s * {24'd0, KA[w_wi]} + {24'd0, KB[w_wi]};
            default: w_new = w_s * {24'd0, KC[w_wi]} + {16'd0, KD[w_wi]};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEED;
            r_idx        <= 3'd0;
            r_step       <= '0;
            r_mask       <= 8'd0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_err_mask   <= 8'd0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
            for (int k = 0; k < 8; k++) begin
                r_cur[k] <= 32'd0;
                r_exp[k] <= 32'd0;
            end
        end else begin
            r_frame_done <= 1'b0;
            if (i_resync) begin
                r_state <= SEED;
                r_idx   <= 3'd0;
                r_mask  <= 8'd0;
                r_step  <= '0;
            end else begin
                case (r_state)
                    SEED: if (w_xfer) begin
                        r_cur[r_idx] <= s_in.in_data;
                        r_idx        <= r_idx + 3'd1;
                        if (w_last) begin
                            for (int k = 0; k < 8; k++)
                                r_exp[k] <= w_frame[k];
                            r_step  <= '0;
                            r_state <= COMPUTE;
                        end
                    end
                    COLLECT: if (w_xfer) begin
                        r_cur[r_idx] <= s_in.in_data;
                        r_idx        <= r_idx + 3'd1;
                        r_mask       <= w_mask;
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_frame_ok   <= (w_mask == 8'd0);
                            r_err_mask   <= w_mask;
                            r_frame_cnt  <= r_frame_cnt + 1'b1;
                            if (w_mask != 8'd0 && !(&r_err_cnt))
                                r_err_cnt <= r_err_cnt + 1'b1;
`ifdef MIX_CHECK_RESYNC_EN
                            for (int k = 0; k < 8; k++)
                                r_exp[k] <= w_frame[k];
`endif
                            r_mask  <= 8'd0;
                            r_step  <= '0;
                            r_state <= COMPUTE;
                        end
                    end
                    COMPUTE: begin
                        r_exp[w_wi] <= w_new;
                        r_step      <= r_step + 1'b1;
                        if (r_step == SW'(STEPS - 1))
                            r_state <= COLLECT;
                    end
                    default: r_state <= SEED;
                endcase
            end
        end
    end

    assign s_in.in_ready   = (r_state != COMPUTE);
    assign o_busy          = (r_state == COMPUTE);
    assign o_frame_done    = r_frame_done;
    assign o_frame_ok      = r_frame_ok;
    assign o_err_word_mask = r_err_mask;
    assign o_frame_cnt     = r_frame_cnt;
    assign o_err_cnt       = r_err_cnt;
endmodule
